// File: rtl/winograd_tile_scheduler.sv
// Walks the output tile grid of a runtime-sized image and sequences one shared Winograd
// F(4x4,3x3) engine. Optional cycle/stall counters are enabled with WINO_SCHED_PERF_EN.
module winograd_tile_scheduler #(
    parameter int unsigned MAX_ROWS = 34,
    parameter int unsigned MAX_COLS = 34,
    parameter int unsigned DIM_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DIM_W-1:0] img_rows_i,
    input  logic [DIM_W-1:0] img_cols_i,
    output logic             load_req_o,
    input  logic             load_ack_i,
    output logic             tc_start_o,
    input  logic             tc_done_i,
    output logic             wr_en_o,
    output logic [DIM_W-1:0] tile_i_o,
    output logic [DIM_W-1:0] tile_j_o,
    output logic [DIM_W-1:0] org_row_o,
    output logic [DIM_W-1:0] org_col_o,
    output logic [2:0]       valid_rows_o,
    output logic [2:0]       valid_cols_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
`ifdef WINO_SCHED_PERF_EN
    output logic             aborted_o,
    output logic [31:0]      perf_cycles_o,
    output logic [31:0]      perf_stall_o
`else
    output logic             aborted_o
`endif
);

    localparam logic [DIM_W-1:0] MinDim  = DIM_W'(3);
    localparam logic [DIM_W-1:0] MaxRows = DIM_W'(MAX_ROWS);
    localparam logic [DIM_W-1:0] MaxCols = DIM_W'(MAX_COLS);
    localparam logic [DIM_W-1:0] Two     = DIM_W'(2);
    localparam logic [DIM_W-1:0] One     = DIM_W'(1);
    localparam logic [DIM_W-1:0] Four    = DIM_W'(4);

    typedef enum logic [2:0] {
        StIdle, StLoad, StCompute, StWrite, StNext, StFin, StFail
    } state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] tile_i_q, tile_i_d, tile_j_q, tile_j_d;
    logic [DIM_W-1:0] out_rows_q, out_rows_d, out_cols_q, out_cols_d;
    logic [DIM_W-1:0] n_ti_q, n_ti_d, n_tj_q, n_tj_d;
    logic             err_q, err_d, aborted_q, aborted_d, first_q, first_d;

    logic [DIM_W-1:0] out_rows_in, out_cols_in, rem_rows, rem_cols;
    logic [DIM_W:0]   rows_rnd, cols_rnd;
    logic             dim_bad, last_i, last_j;

    assign out_rows_in = img_rows_i - Two;
    assign out_cols_in = img_cols_i - Two;
    assign rows_rnd    = {1'b0, out_rows_in} + (DIM_W+1)'(3);
    assign cols_rnd    = {1'b0, out_cols_in} + (DIM_W+1)'(3);
    assign dim_bad     = (img_rows_i < MinDim) || (img_cols_i < MinDim) ||
                         (img_rows_i > MaxRows) || (img_cols_i > MaxCols);

    assign org_row_o    = {tile_i_q[DIM_W-3:0], 2'b00};
    assign org_col_o    = {tile_j_q[DIM_W-3:0], 2'b00};
    assign rem_rows     = out_rows_q - org_row_o;
    assign rem_cols     = out_cols_q - org_col_o;
    assign valid_rows_o = (rem_rows >= Four) ? 3'd4 : rem_rows[2:0];
    assign valid_cols_o = (rem_cols >= Four) ? 3'd4 : rem_cols[2:0];
    assign last_i       = (tile_i_q == n_ti_q - One);
    assign last_j       = (tile_j_q == n_tj_q - One);

    assign tile_i_o  = tile_i_q;
    assign tile_j_o  = tile_j_q;
    assign err_o     = err_q;
    assign aborted_o = aborted_q;

    always_comb begin
        state_d    = state_q;
        tile_i_d   = tile_i_q;
        tile_j_d   = tile_j_q;
        out_rows_d = out_rows_q;
        out_cols_d = out_cols_q;
        n_ti_d     = n_ti_q;
        n_tj_d     = n_tj_q;
        err_d      = err_q;
        aborted_d  = 1'b0;
        first_d    = 1'b0;
        load_req_o = 1'b0;
        tc_start_o = 1'b0;
        wr_en_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (dim_bad) begin
                        err_d   = 1'b1;
                        state_d = StFail;
                    end else begin
                        out_rows_d = out_rows_in;
                        out_cols_d = out_cols_in;
                        n_ti_d     = DIM_W'(rows_rnd[DIM_W:2]);
                        n_tj_d     = DIM_W'(cols_rnd[DIM_W:2]);
                        tile_i_d   = '0;
                        tile_j_d   = '0;
                        err_d      = 1'b0;
                        state_d    = StLoad;
                    end
                end
            end
            StLoad: begin
                busy_o     = 1'b1;
                load_req_o = 1'b1;
                if (load_ack_i) begin
                    first_d = 1'b1;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                busy_o     = 1'b1;
                tc_start_o = first_q;
                if (tc_done_i) state_d = StWrite;
            end
            StWrite: begin
                busy_o  = 1'b1;
                wr_en_o = 1'b1;
                state_d = StNext;
            end
            StNext: begin
                busy_o = 1'b1;
                if (last_i && last_j) begin
                    state_d = StFin;
                end else begin
                    state_d = StLoad;
                    if (last_j) begin
                        tile_j_d = '0;
                        tile_i_d = tile_i_q + One;
                    end else begin
                        tile_j_d = tile_j_q + One;
                    end
                end
            end
            StFin, StFail: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over any handshake sampled in the same cycle.
        if (abort_i && (state_q != StIdle)) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
            first_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            tile_i_q   <= '0;
            tile_j_q   <= '0;
            out_rows_q <= '0;
            out_cols_q <= '0;
            n_ti_q     <= '0;
            n_tj_q     <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_i_q   <= tile_i_d;
            tile_j_q   <= tile_j_d;
            out_rows_q <= out_rows_d;
            out_cols_q <= out_cols_d;
            n_ti_q     <= n_ti_d;
            n_tj_q     <= n_tj_d;
            err_q      <= err_d;
            aborted_q  <= aborted_d;
            first_q    <= first_d;
        end
    end

`ifdef WINO_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_stall_q;
    logic        stall;

    assign stall = ((state_q == StLoad) && !load_ack_i) ||
                   ((state_q == StCompute) && !tc_done_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if ((state_q == StIdle) && start_i) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy_o) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (stall)  perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: doc/winograd_tile_scheduler.md
Name: winograd_tile_scheduler

Overview:
Sequences one shared Winograd F(4x4,3x3) tile engine across a runtime-sized image. It walks the output tile grid in row-major order. For each tile it requests the 6x6 input window, starts the engine, waits for completion, then issues a write-back strobe with edge-clipping information. It replaces the fixed-size round/tile sequencing inside the per-size convolution wrappers, so a single wrapper can serve any image up to MAX_ROWS x MAX_COLS.

Parameters:
MAX_ROWS, 34, maximum input image rows accepted
MAX_COLS, 34, maximum input image cols accepted
DIM_W, 8, width of dimension, origin and tile-index fields

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a convolution; ignored unless idle
abort  in  1  cancel the current job
img_rows  in  DIM_W  input rows; sampled only on an accepted start
img_cols  in  DIM_W  input cols; sampled only on an accepted start
load_req  out  1  request to fetch the 6x6 window at (org_row, org_col)
load_ack  in  1  window captured; may arrive in the same cycle as load_req
tc_start  out  1  one-cycle start pulse to the tile engine
tc_done  in  1  tile engine finished
wr_en  out  1  one-cycle strobe: write the current 4x4 result tile
tile_i  out  DIM_W  current tile row index
tile_j  out  DIM_W  current tile col index
org_row  out  DIM_W  input window origin row, equal to tile_i*4
org_col  out  DIM_W  input window origin col, equal to tile_j*4
valid_rows  out  3  rows of the current tile inside the output, 1..4
valid_cols  out  3  cols of the current tile inside the output, 1..4
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
err  out  1  dimension error flag for the last job
aborted  out  1  one-cycle pulse when abort is taken

Behaviour:
- Reset: all outputs are 0; state returns to IDLE.
- Derived values on accepted start:
  - out_rows = img_rows-2, out_cols = img_cols-2.
  - n_ti = ceil(out_rows/4), n_tj = ceil(out_cols/4).
  - All are registered; the latched values stay fixed for the whole job.
- Tile edge clipping: valid_rows = min(4, out_rows - 4*tile_i); valid_cols uses the same rule with out_cols and tile_j.
- State machine, one transition per clock:
  - IDLE: on start, if img_rows<3, img_cols<3, img_rows>MAX_ROWS or img_cols>MAX_COLS, go to FAIL. Otherwise clear tile_i and tile_j, set busy=1, set err=0, and go to LOAD.
  - LOAD: load_req=1 while in this state. Go to COMPUTE in the cycle load_ack=1.
  - COMPUTE: tc_start=1 on the first cycle only. Stay until tc_done=1, then go to WRITE. tc_done arriving on the tc_start cycle is accepted.
  - WRITE: wr_en=1 for exactly one cycle, then go to NEXT.
  - NEXT: if tile_j<n_tj-1, increment tile_j. Otherwise set tile_j=0 and increment tile_i. Go to LOAD. If the tile just written was the last tile, go to FIN instead.
  - FIN: done=1 and busy=0 in this cycle, then go to IDLE.
  - FAIL: err=1 (sticky until the next accepted start), done=1, busy=0, then go to IDLE. No load_req, tc_start or wr_en is ever issued for a failed job.
- Field stability: tile_i, tile_j, org_* and valid_* hold stable from LOAD through WRITE of a tile.
- Abort: abort=1 in any state other than IDLE sends the block to IDLE next cycle. aborted pulses, busy=0, done stays 0, and no further strobes are issued. Abort in IDLE is ignored. Abort has priority over load_ack and tc_done in the same cycle.
- start while busy is ignored; the latched dimensions are unaffected.
- rst has priority over everything, including mid-job.
- Minimum per-tile cost with immediate ack and immediate tc_done: LOAD 1 + COMPUTE 1 + WRITE 1 + NEXT 1 = 4 cycles.

Optional Feature:
WINO_SCHED_PERF_EN
- Defined: adds output perf_cycles (32 bits) and output perf_stall (32 bits).
  - perf_cycles counts cycles with busy=1.
  - perf_stall counts cycles spent in LOAD with load_ack=0 or in COMPUTE with tc_done=0.
  - Both clear on an accepted start, hold after done, and reset to 0.
- Undefined: neither port nor the counters exist. Functional behaviour is identical.

Test Plan:
1. 10x12 image, load_ack tied high, tc_done 3 cycles after tc_start -> exactly 6 tc_start and 6 wr_en pulses. (tile_i,tile_j) sequence is (0,0)(0,1)(0,2)(1,0)(1,1)(1,2). org_col is 0,4,8. Column-2 tiles have valid_cols=2 and all tiles have valid_rows=4. One done pulse, err=0.
2. 3x3 image with immediate handshakes -> a single tile at origin (0,0) with valid_rows=1 and valid_cols=1. done is asserted exactly 4 cycles after the LOAD entry cycle.
3. img_rows=2, img_cols=12 -> FAIL: err=1 and a done pulse on the cycle after start. Zero load_req, tc_start and wr_en. Then a valid 6x6 start clears err.
4. load_ack held low for 5 cycles on tile (0,1) -> load_req stays high for those cycles and no tc_start occurs until ack. Under WINO_SCHED_PERF_EN, perf_stall increases by 5.
5. abort asserted during COMPUTE of tile (1,0) together with tc_done -> no wr_en, one aborted pulse, done never pulses, busy=0 next cycle. A new start then runs from (0,0).
6. start pulsed again mid-job with img_cols=34 -> ignored. The job finishes with the original grid, and rst mid-job zeroes all outputs on the next edge.
